// File: rtl/shift_rotate_pkg.sv
// -----------------------------------------------------------------------------
// shift_rotate_pkg
//
// Shared definitions for the parametrised shift/rotate register:
//   - operation mode encodings (2-bit `mode` port values)
//   - FSM state type for the top-level controller
// -----------------------------------------------------------------------------
package shift_rotate_pkg;

    // Operation select values as presented on the mode port.
    localparam logic [1:0] MODE_ROR = 2'b00;  // rotate right
    localparam logic [1:0] MODE_ROL = 2'b01;  // rotate left
    localparam logic [1:0] MODE_ASR = 2'b10;  // arithmetic shift right
    localparam logic [1:0] MODE_LSL = 2'b11;  // logical shift left

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : shift_rotate_pkg

// File: rtl/shift_step_unit.sv
// -----------------------------------------------------------------------------
// shift_step_unit
//
// Purely combinational single-position step of the shift/rotate register.
// Given the current word and a mode, produces the word after one step and,
// when SHIFT_ROTATE_CARRY_EN is defined, the bit that leaves the word.
//
// Configuration macro: SHIFT_ROTATE_CARRY_EN (adds bit_out_o).
//
// Ports:
//   q_i        in  WIDTH  current register contents
//   mode_i     in  2      ROR / ROL / ASR / LSL select
//   next_q_o   out WIDTH  contents after one step
//   bit_out_o  out 1      bit shifted out of the word (carry build only)
// -----------------------------------------------------------------------------
module shift_step_unit
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] next_q_o
`ifdef SHIFT_ROTATE_CARRY_EN
    ,
    output logic             bit_out_o
`endif
);

    always_comb begin
        next_q_o = q_i;
        unique case (mode_i)
            MODE_ROR: next_q_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ROL: next_q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ASR: next_q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_LSL: next_q_o = {q_i[WIDTH-2:0], 1'b0};
            default:  next_q_o = q_i;
        endcase
    end

`ifdef SHIFT_ROTATE_CARRY_EN
    // Right-moving modes drop the LSB, left-moving modes drop the MSB.
    always_comb begin
        bit_out_o = q_i[0];
        if ((mode_i == MODE_ROL) || (mode_i == MODE_LSL)) begin
            bit_out_o = q_i[WIDTH-1];
        end
    end
`endif

endmodule : shift_step_unit

// File: rtl/param_shift_rotate_reg.sv
// -----------------------------------------------------------------------------
// param_shift_rotate_reg
//
// WIDTH-bit register with synchronous parallel load and a multi-step
// shift/rotate engine that moves one bit position per clock. An operation is
// launched with start (amount steps of the selected mode); busy is high while
// stepping and done pulses for one cycle when the result is in q.
//
// Configuration macro: SHIFT_ROTATE_CARRY_EN
//   defined   -> carry_out port holds the last bit shifted out of the word
//   undefined -> no carry_out port, no carry logic
//
// Ports:
//   clk        in  1      system clock, rising edge
//   resetn     in  1      asynchronous active-low reset
//   load       in  1      parallel load request (IDLE only, beats start)
//   data_in    in  WIDTH  parallel load data
//   start      in  1      launch an operation (IDLE only)
//   mode       in  2      00 ROR, 01 ROL, 10 ASR, 11 LSL
//   amount     in  AW     step count 0..WIDTH, larger values clamp to WIDTH
//   q          out WIDTH  register contents
//   busy       out 1      high while stepping
//   done       out 1      one-cycle completion pulse
//   carry_out  out 1      last bit shifted out (carry build only)
// -----------------------------------------------------------------------------
module param_shift_rotate_reg
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef SHIFT_ROTATE_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    cnt_q;
    logic [1:0]       mode_q;
    logic             busy_q;
    logic             done_q;

    logic [AW-1:0]    amount_d;
    logic [WIDTH-1:0] data_d;

`ifdef SHIFT_ROTATE_CARRY_EN
    logic             carry_q;
    logic             carry_d;
`endif

    // Requests beyond WIDTH steps saturate; WIDTH steps already reach the
    // fixed point of every mode (rotate = identity, shifts = fill).
    always_comb begin
        amount_d = amount;
        if (amount > AMT_MAX) begin
            amount_d = AMT_MAX;
        end
    end

    // Step datapath operates on the latched mode so mid-operation changes on
    // the mode port cannot affect the running operation.
    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i       (data_q),
        .mode_i    (mode_q),
        .next_q_o  (data_d)
`ifdef SHIFT_ROTATE_CARRY_EN
        ,
        .bit_out_o (carry_d)
`endif
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ROR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_ROTATE_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        data_q  <= data_in;
`ifdef SHIFT_ROTATE_CARRY_EN
                        carry_q <= 1'b0;
`endif
                    end else if (start) begin
                        if (amount == '0) begin
                            // Zero-length operation completes without SHIFT.
                            done_q <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            cnt_q   <= amount_d;
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    data_q <= data_d;
`ifdef SHIFT_ROTATE_CARRY_EN
                    carry_q <= carry_d;
`endif
                    cnt_q  <= cnt_q - AMT_ONE;
                    if (cnt_q == AMT_ONE) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign q    = data_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SHIFT_ROTATE_CARRY_EN
    assign carry_out = carry_q;
`endif

endmodule : param_shift_rotate_reg

// File: doc/param_shift_rotate_reg.md
Name: param_shift_rotate_reg

Overview:
- Parametrised successor of the lab 8-bit rotating register.
- Holds a WIDTH-bit word with synchronous parallel load.
- Runs a multi-step shift/rotate of up to WIDTH positions, moving one bit position per clock, with a start/busy/done handshake.
- Four modes: rotate right, rotate left, arithmetic shift right, logical shift left. Sits between switch/key input logic and LED/HEX display logic.

Parameters:
- WIDTH, 8: register width in bits; legal range is 2 or more.
- AW, $clog2(WIDTH)+1: width of the amount port, so that amount can equal WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- load  in  1  parallel-load request; sampled in IDLE only.
- data_in  in  WIDTH  parallel load data.
- start  in  1  begin an operation; sampled in IDLE only.
- mode  in  2  operation select: 00 ROR, 01 ROL, 10 ASR, 11 LSL.
- amount  in  AW  number of single-bit steps, 0..WIDTH; values above WIDTH are clamped to WIDTH.
- q  out  WIDTH  register contents.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asserting resetn low immediately forces the following, regardless of clk, including mid-operation with the operation discarded:
  - state = IDLE
  - q = 0, count = 0, busy = 0, done = 0
- States:
  - IDLE: accepts load or start.
  - SHIFT: performs one step per edge; count decrements each edge.
- IDLE transitions (priority load > start):
  - load=1: q <= data_in; start is ignored that cycle; done = 0.
  - start=1, amount=0: q unchanged; state stays IDLE; done = 1 next cycle; busy stays 0.
  - start=1, amount=N>0: mode and min(N,WIDTH) are latched; state <= SHIFT; busy = 1 next cycle. q is not modified on the start edge.
- SHIFT:
  - Each edge applies one step of the latched mode and decrements count.
  - The edge where count goes 1 -> 0 applies the final step, sets state <= IDLE, busy <= 0 and done <= 1.
  - Total: N step edges after the start edge. done is high in the single cycle following the final step edge, and q is final in that same cycle.
- done is registered and high for exactly one cycle per accepted start. It is 0 on every other cycle, including load cycles.
- In SHIFT, load, start, mode and amount are ignored; changing them mid-operation has no effect. There is no abort except reset.
- Step definitions, one position per step:
  - ROR: q <= {q[0], q[WIDTH-1:1]}
  - ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}
  - LSL: q <= {q[WIDTH-2:0], 1'b0}
- Boundaries:
  - Rotate by WIDTH returns the original value.
  - ASR by WIDTH yields all copies of the original MSB.
  - LSL by WIDTH yields 0.
- A start asserted in the same cycle that done is high is accepted, because state is IDLE. This allows back-to-back operations with one idle cycle between them.

Optional Feature:
- Macro: SHIFT_ROTATE_CARRY_EN.
- Defined:
  - Adds output port carry_out (1 bit, reset 0).
  - On every step edge, carry_out <= the bit leaving the word: q[0] for ROR/ASR, q[WIDTH-1] for ROL/LSL.
  - On a load edge, carry_out <= 0.
  - carry_out holds its value otherwise; it equals the last bit shifted out when done is high.
  - amount=0 leaves carry_out unchanged.
- Undefined: no carry_out port and no carry logic; all other behaviour is identical.

Decomposition:
- Package shift_rotate_pkg:
  - Mode encoding constants MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_ASR=2'b10, MODE_LSL=2'b11.
  - FSM state encoding ST_IDLE, ST_SHIFT.
- One natural sub-module: shift_step_unit. It is purely combinational: inputs q and mode; outputs the next-q and the shifted-out bit. The top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=8. Load 0x96, start ROR amount=3 -> busy high for 3 cycles; done pulses once; q=0xD2; carry_out=1 (when SHIFT_ROTATE_CARRY_EN is defined).
- Load 0x96, start ASR amount=2 -> q=0xE5. Then ASR amount=8 on reloaded 0x96 -> q=0xFF.
- Load 0x96, LSL amount=3 -> q=0xB0, carry_out=0. ROL amount=8 on 0x96 -> q=0x96. ROL amount=1 on 0x81 -> q=0x03.
- Start with amount=0 -> no busy; done pulses the next cycle; q unchanged. amount=15 -> clamped to 8 steps (busy 8 cycles).
- load and start asserted together in IDLE -> q=data_in, no busy, no done. load during SHIFT -> ignored; final q matches the uninterrupted result.
- resetn pulled low mid-SHIFT, asynchronously between edges -> q=0, busy=0, done=0 immediately. After release, a new start operates normally.
